// File: rtl/hssl_reg_pkt_ctl.sv
// Packet-side register access controller: decodes config packets into register writes/reads and emits reply packets.
// Optional reply timeout is enabled by defining HSSL_RPY_TIMEOUT_EN.
`ifndef REG_ADR_BITS
`define REG_ADR_BITS 8
`endif

module hssl_reg_pkt_ctl #(
    parameter logic [31:0] CFG_KEY  = 32'hffff_fe00,
    parameter logic [31:0] CFG_MASK = 32'hffff_ff00,
    parameter int          RPY_TMO  = 1024
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [31:0]              reply_key_in,
    input  logic [31:0]              pkt_key_in,
    input  logic [31:0]              pkt_data_in,
    input  logic                     pkt_pl_in,
    input  logic                     pkt_vld_in,
    output logic                     pkt_rdy_out,
    output logic [`REG_ADR_BITS-1:0] prx_addr_out,
    output logic [31:0]              prx_wdata_out,
    output logic                     prx_en_out,
    output logic [`REG_ADR_BITS-1:0] rd_addr_out,
    output logic                     rd_en_out,
    input  logic [31:0]              rd_data_in,
    output logic [31:0]              rpy_key_out,
    output logic [31:0]              rpy_data_out,
    output logic                     rpy_vld_out,
    input  logic                     rpy_rdy_in,
    output logic                     drop_out,
    output logic                     rpy_tmo_out
);

    localparam int AW = `REG_ADR_BITS;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RDWAIT,
        REPLY
    } state_t;

    if (RPY_TMO < 1 || RPY_TMO > 65535) begin : g_bad_tmo
        $error("RPY_TMO out of range");
    end
    if ((CFG_MASK & ((32'd1 << AW) - 32'd1)) != 32'd0) begin : g_bad_mask
        $error("CFG_MASK overlaps the register address bits");
    end

    state_t        state_q, state_d;
    logic          rdy_q, rdy_d;
    logic          drop_q, drop_d;
    logic          tmo_q, tmo_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   key_q, key_d;
    logic [31:0]   data_q, data_d;

    logic accept;
    logic match;
    logic rpy_tmo;

    // rdy_q is only ever set while IDLE, so it doubles as the accept qualifier
    assign accept = rdy_q & pkt_vld_in;
    assign match  = (pkt_key_in & CFG_MASK) == CFG_KEY;

`ifdef HSSL_RPY_TIMEOUT_EN
    localparam int CW = $clog2(RPY_TMO + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(RPY_TMO - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (state_q == REPLY && !rpy_rdy_in) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign rpy_tmo = (state_q == REPLY) & ~rpy_rdy_in & (cnt_q == TMO_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign rpy_tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        key_d   = key_q;
        data_d  = data_q;
        drop_d  = 1'b0;
        tmo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (match) begin
                        addr_d  = pkt_key_in[AW-1:0];
                        wdata_d = pkt_data_in;
                        state_d = pkt_pl_in ? WRITE : READ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            WRITE:  state_d = IDLE;
            READ:   state_d = RDWAIT;
            RDWAIT: begin
                data_d  = rd_data_in;
                key_d   = reply_key_in | 32'(addr_q);
                state_d = REPLY;
            end
            REPLY: begin
                // acceptance beats a coincident timeout
                if (rpy_rdy_in) begin
                    state_d = IDLE;
                end else if (rpy_tmo) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            drop_q  <= 1'b0;
            tmo_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            key_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            drop_q  <= drop_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            key_q   <= key_d;
            data_q  <= data_d;
        end
    end

    assign pkt_rdy_out   = rdy_q;
    assign prx_addr_out  = addr_q;
    assign prx_wdata_out = wdata_q;
    assign prx_en_out    = (state_q == WRITE);
    assign rd_addr_out   = addr_q;
    assign rd_en_out     = (state_q == READ);
    assign rpy_key_out   = key_q;
    assign rpy_data_out  = data_q;
    assign rpy_vld_out   = (state_q == REPLY);
    assign drop_out      = drop_q;
    assign rpy_tmo_out   = tmo_q;

endmodule
